ext_tid_arb_ipa: RTL and testbench

//  Owns the external transaction-ID pool shared by the ext TX (write) and RX (read) AXI

---
 rtl/ext_tid_arb_ipa.sv | 116 +++++++++++
 tb/tb_ext_tid_arb_ipa.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_tid_arb_ipa.sv
// External transaction-ID pool shared by the ext TX (write) and RX (read) request paths.
// Offers the lowest free ID each cycle to one requester (round-robin when both ask),
// tracks outstanding IDs in a free bitmap, frees IDs on completion and flags misuse.
module ext_tid_arb_ipa #(
  parameter int EXT_TID_WIDTH = 4,
  parameter int NB_TID        = 2**EXT_TID_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     tx_req_i,
  input  logic                     rx_req_i,
  output logic                     tx_valid_tid_o,
  output logic                     rx_valid_tid_o,
  output logic [EXT_TID_WIDTH-1:0] tid_o,
  input  logic                     tx_alloc_i,
  input  logic                     rx_alloc_i,
  input  logic                     tx_release_i,
  input  logic [EXT_TID_WIDTH-1:0] tx_res_tid_i,
  input  logic                     rx_release_i,
  input  logic [EXT_TID_WIDTH-1:0] rx_res_tid_i,
  output logic [EXT_TID_WIDTH:0]   outstanding_o,
  output logic                     idle_o,
  output logic                     err_o
);

  localparam int NB_MAX = 2**EXT_TID_WIDTH;
  localparam int CW     = EXT_TID_WIDTH + 1;
  localparam logic [CW-1:0] NB_LIM = CW'(NB_TID);

  // Bitmap with one bit set per usable ID; IDs at or above NB_TID stay permanently 0.
  function automatic logic [NB_MAX-1:0] pool_mask();
    logic [NB_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < NB_TID; i++) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [NB_MAX-1:0] FREE_INIT = pool_mask();

  // Counter update clamped to the legal range 0..NB_TID so it can never wrap.
  function automatic logic [CW-1:0] sat_count(input logic [CW-1:0] cnt, input logic add,
                                              input logic sub_a, input logic sub_b);
    int s;
    s = int'(cnt) + int'(add) - int'(sub_a) - int'(sub_b);
    if (s < 0) s = 0;
    if (s > NB_TID) s = NB_TID;
    return CW'(s);
  endfunction

  logic [NB_MAX-1:0]        free_p0;
  logic                     rr_rx_p0;
  logic                     err_p0;
  logic [CW-1:0]            outstanding_p0;

  logic [EXT_TID_WIDTH-1:0] low_tid;
  logic                     pool_nonempty;
  logic                     tx_grant, rx_grant;
  logic                     tx_take, rx_take, alloc_bad;
  logic                     same_tid, tx_rel_ok, rx_rel_ok, rel_bad;
  logic [NB_MAX-1:0]        free_next;

  // Priority encoder: lowest-index free ID from the registered bitmap only.
  always_comb begin
    low_tid = '0;
    for (int i = NB_MAX - 1; i >= 0; i--) begin
      if (free_p0[i]) low_tid = EXT_TID_WIDTH'(i);
    end
  end

  assign pool_nonempty = |free_p0;
  assign tx_grant  = pool_nonempty & tx_req_i & (~rx_req_i | ~rr_rx_p0);
  assign rx_grant  = pool_nonempty & rx_req_i & (~tx_req_i |  rr_rx_p0);
  assign tx_take   = tx_alloc_i & tx_grant;
  assign rx_take   = rx_alloc_i & rx_grant;
  assign alloc_bad = (tx_alloc_i & ~tx_grant) | (rx_alloc_i & ~rx_grant);

  // A release is honoured only for an in-range ID that is currently allocated;
  // the same ID on both ports is freed once through the TX port.
  assign same_tid  = tx_release_i & rx_release_i & (tx_res_tid_i == rx_res_tid_i);
  assign tx_rel_ok = tx_release_i & ({1'b0, tx_res_tid_i} < NB_LIM) & ~free_p0[tx_res_tid_i];
  assign rx_rel_ok = rx_release_i & ~same_tid & ({1'b0, rx_res_tid_i} < NB_LIM)
                   & ~free_p0[rx_res_tid_i];
  assign rel_bad   = (tx_release_i & ~tx_rel_ok) | (rx_release_i & ~rx_rel_ok);

  // Next bitmap: clear the allocated ID, set the released ones (all distinct bits).
  always_comb begin
    free_next = free_p0;
    if (tx_take | rx_take) free_next[low_tid] = 1'b0;
    if (tx_rel_ok) free_next[tx_res_tid_i] = 1'b1;
    if (rx_rel_ok) free_next[rx_res_tid_i] = 1'b1;
  end

  // ---- stage p0: pool state, round-robin pointer, error flag, outstanding count ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      free_p0        <= FREE_INIT;
      rr_rx_p0       <= 1'b1;
      err_p0         <= 1'b0;
      outstanding_p0 <= '0;
    end else begin
      free_p0 <= free_next;
      if (tx_take)      rr_rx_p0 <= 1'b1;
      else if (rx_take) rr_rx_p0 <= 1'b0;
      if (alloc_bad | rel_bad) err_p0 <= 1'b1;
      outstanding_p0 <= sat_count(outstanding_p0, tx_take | rx_take, tx_rel_ok, rx_rel_ok);
    end
  end

  assign tx_valid_tid_o = tx_grant;
  assign rx_valid_tid_o = rx_grant;
  assign tid_o          = low_tid;
  assign outstanding_o  = outstanding_p0;
  assign idle_o         = (outstanding_p0 == '0);
  assign err_o          = err_p0;

endmodule

// File: tb/tb_ext_tid_arb_ipa.sv
// Bench for ext_tid_arb_ipa: directed scenarios plus randomized traffic against a
// set-of-allocated-IDs reference model.
module tb_ext_tid_arb_ipa;
  localparam int W  = 4;
  localparam int NB = 16;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         tx_req_i = 1'b0, rx_req_i = 1'b0;
  logic         tx_valid_tid_o, rx_valid_tid_o;
  logic [W-1:0] tid_o;
  logic         tx_alloc_i = 1'b0, rx_alloc_i = 1'b0;
  logic         tx_release_i = 1'b0, rx_release_i = 1'b0;
  logic [W-1:0] tx_res_tid_i = '0, rx_res_tid_i = '0;
  logic [W:0]   outstanding_o;
  logic         idle_o, err_o;

  int checks = 0;
  int failures = 0;

  // Reference model: which IDs are held, sticky error, and whose turn it is on a tie.
  bit m_alloc[NB];
  bit m_err;
  bit m_rx_turn;

  always #5 clk = ~clk;

  ext_tid_arb_ipa #(.EXT_TID_WIDTH(W), .NB_TID(NB)) dut (
    .clk_i(clk), .rst_i(rst_i), .tx_req_i(tx_req_i), .rx_req_i(rx_req_i),
    .tx_valid_tid_o(tx_valid_tid_o), .rx_valid_tid_o(rx_valid_tid_o), .tid_o(tid_o),
    .tx_alloc_i(tx_alloc_i), .rx_alloc_i(rx_alloc_i),
    .tx_release_i(tx_release_i), .tx_res_tid_i(tx_res_tid_i),
    .rx_release_i(rx_release_i), .rx_res_tid_i(rx_res_tid_i),
    .outstanding_o(outstanding_o), .idle_o(idle_o), .err_o(err_o));

  function automatic int m_lowest();
    for (int i = 0; i < NB; i++) if (!m_alloc[i]) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NB; i++) if (m_alloc[i]) c++;
    return c;
  endfunction

  function automatic bit m_tx_valid();
    return (m_lowest() >= 0) && tx_req_i && (!rx_req_i || !m_rx_turn);
  endfunction

  function automatic bit m_rx_valid();
    return (m_lowest() >= 0) && rx_req_i && (!tx_req_i || m_rx_turn);
  endfunction

  // One clock: evaluate the model on the current inputs, advance past the edge.
  task automatic tick();
    bit nf[NB];
    bit nerr, nturn, tv, rv;
    int low;
    low = m_lowest(); tv = m_tx_valid(); rv = m_rx_valid();
    nf = m_alloc; nerr = m_err; nturn = m_rx_turn;
    if (rst_i) begin
      foreach (nf[i]) nf[i] = 1'b0;
      nerr = 1'b0; nturn = 1'b1;
    end else begin
      if (tx_alloc_i) begin
        if (tv) begin nf[low] = 1'b1; nturn = 1'b1; end else nerr = 1'b1;
      end
      if (rx_alloc_i) begin
        if (rv) begin nf[low] = 1'b1; nturn = 1'b0; end else nerr = 1'b1;
      end
      if (tx_release_i) begin
        if (int'(tx_res_tid_i) >= NB || !m_alloc[tx_res_tid_i]) nerr = 1'b1;
        else nf[tx_res_tid_i] = 1'b0;
      end
      if (rx_release_i) begin
        if (tx_release_i && tx_res_tid_i == rx_res_tid_i) nerr = 1'b1;
        else if (int'(rx_res_tid_i) >= NB || !m_alloc[rx_res_tid_i]) nerr = 1'b1;
        else nf[rx_res_tid_i] = 1'b0;
      end
    end
    @(posedge clk);
    m_alloc = nf; m_err = nerr; m_rx_turn = nturn;
    #1;
  endtask

  task automatic clear_inputs();
    tx_req_i = 0; rx_req_i = 0; tx_alloc_i = 0; rx_alloc_i = 0;
    tx_release_i = 0; rx_release_i = 0; tx_res_tid_i = '0; rx_res_tid_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (outstanding_o !== 5'd0) begin failures++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding_o); end
    checks++; if (idle_o !== 1'b1) begin failures++; $display("FAIL reset_idle got=%0b exp=1", idle_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err_o); end
    checks++; if ({tx_valid_tid_o, rx_valid_tid_o} !== 2'b00) begin failures++; $display("FAIL reset_valids got=%b exp=00", {tx_valid_tid_o, rx_valid_tid_o}); end
    tx_req_i = 1'b1; #1;
    checks++; if ({tx_valid_tid_o, rx_valid_tid_o} !== 2'b10) begin failures++; $display("FAIL txonly_valids got=%b exp=10", {tx_valid_tid_o, rx_valid_tid_o}); end
    checks++; if (tid_o !== 4'd0) begin failures++; $display("FAIL txonly_tid got=%0d exp=0", tid_o); end
  endtask

  task automatic test_single_tx();
    tx_alloc_i = 1'b1;
    tick();
    tx_alloc_i = 1'b0; #1;
    checks++; if (tid_o !== 4'd1) begin failures++; $display("FAIL single_tid got=%0d exp=1", tid_o); end
    checks++; if (outstanding_o !== 5'd1) begin failures++; $display("FAIL single_outstanding got=%0d exp=1", outstanding_o); end
    checks++; if (idle_o !== 1'b0) begin failures++; $display("FAIL single_idle got=%0b exp=0", idle_o); end
  endtask

  task automatic test_rr_alternate();
    bit exp_rx;
    do_reset();
    tx_req_i = 1'b1; rx_req_i = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      exp_rx = (i % 2 == 0);
      checks++; if ({tx_valid_tid_o, rx_valid_tid_o} !== {~exp_rx, exp_rx}) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", i, {tx_valid_tid_o, rx_valid_tid_o}, {~exp_rx, exp_rx}); end
      checks++; if (tid_o !== W'(i)) begin failures++; $display("FAIL rr_tid%0d got=%0d exp=%0d", i, tid_o, i); end
      if (exp_rx) rx_alloc_i = 1'b1; else tx_alloc_i = 1'b1;
      tick();
      tx_alloc_i = 1'b0; rx_alloc_i = 1'b0; #1;
    end
  endtask

  task automatic test_fill_and_release();
    do_reset();
    tx_req_i = 1'b1; tx_alloc_i = 1'b1;
    repeat (NB) tick();
    tx_alloc_i = 1'b0; rx_req_i = 1'b1; #1;
    checks++; if ({tx_valid_tid_o, rx_valid_tid_o} !== 2'b00) begin failures++; $display("FAIL full_valids got=%b exp=00", {tx_valid_tid_o, rx_valid_tid_o}); end
    checks++; if (outstanding_o !== 5'd16) begin failures++; $display("FAIL full_outstanding got=%0d exp=16", outstanding_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL full_err got=%0b exp=0", err_o); end
    tx_req_i = 1'b0; rx_release_i = 1'b1; rx_res_tid_i = 4'd5;
    tick();
    rx_release_i = 1'b0; #1;
    checks++; if (rx_valid_tid_o !== 1'b1) begin failures++; $display("FAIL refill_rxvalid got=%0b exp=1", rx_valid_tid_o); end
    checks++; if (tid_o !== 4'd5) begin failures++; $display("FAIL refill_tid got=%0d exp=5", tid_o); end
    checks++; if (outstanding_o !== 5'd15) begin failures++; $display("FAIL refill_outstanding got=%0d exp=15", outstanding_o); end
  endtask

  task automatic test_dual_release();
    do_reset();
    tx_req_i = 1'b1; tx_alloc_i = 1'b1;
    repeat (8) tick();
    tx_alloc_i = 1'b0;
    tx_release_i = 1'b1; tx_res_tid_i = 4'd2;
    rx_release_i = 1'b1; rx_res_tid_i = 4'd7;
    tick();
    tx_release_i = 1'b0; rx_release_i = 1'b0; #1;
    checks++; if (outstanding_o !== 5'd6) begin failures++; $display("FAIL dual_outstanding got=%0d exp=6", outstanding_o); end
    checks++; if (tid_o !== 4'd2) begin failures++; $display("FAIL dual_tid got=%0d exp=2", tid_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL dual_err got=%0b exp=0", err_o); end
  endtask

  task automatic test_alloc_release_same();
    do_reset();
    tx_req_i = 1'b1; tx_alloc_i = 1'b1;
    repeat (2) tick();
    tx_release_i = 1'b1; tx_res_tid_i = 4'd0; #1;
    checks++; if (tid_o !== 4'd2) begin failures++; $display("FAIL same_tid_now got=%0d exp=2", tid_o); end
    tick();
    tx_alloc_i = 1'b0; tx_release_i = 1'b0; #1;
    checks++; if (tid_o !== 4'd0) begin failures++; $display("FAIL same_tid_next got=%0d exp=0", tid_o); end
    checks++; if (outstanding_o !== 5'd2) begin failures++; $display("FAIL same_outstanding got=%0d exp=2", outstanding_o); end
  endtask

  task automatic test_errors();
    do_reset();
    rx_release_i = 1'b1; rx_res_tid_i = 4'd9;
    tick();
    rx_release_i = 1'b0; #1;
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL freerel_err got=%0b exp=1", err_o); end
    checks++; if (outstanding_o !== 5'd0) begin failures++; $display("FAIL freerel_outstanding got=%0d exp=0", outstanding_o); end
    do_reset(); #1;
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL err_cleared got=%0b exp=0", err_o); end
    rx_alloc_i = 1'b1;
    tick();
    rx_alloc_i = 1'b0; #1;
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL badalloc_err got=%0b exp=1", err_o); end
    checks++; if (outstanding_o !== 5'd0) begin failures++; $display("FAIL badalloc_outstanding got=%0d exp=0", outstanding_o); end
    do_reset();
    tx_req_i = 1'b1; tx_alloc_i = 1'b1;
    tick();
    tx_req_i = 1'b0; tx_alloc_i = 1'b0;
    tx_release_i = 1'b1; rx_release_i = 1'b1; tx_res_tid_i = 4'd0; rx_res_tid_i = 4'd0;
    tick();
    tx_release_i = 1'b0; rx_release_i = 1'b0; #1;
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL samerel_err got=%0b exp=1", err_o); end
    checks++; if (outstanding_o !== 5'd0) begin failures++; $display("FAIL samerel_outstanding got=%0d exp=0", outstanding_o); end
  endtask

  task automatic test_random();
    int q[$];
    int low, exp_tid, exp_cnt;
    bit tv, rv;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      rst_i    = ($urandom_range(0, 149) == 0);
      tx_req_i = $urandom_range(0, 1);
      rx_req_i = $urandom_range(0, 1);
      tv = m_tx_valid(); rv = m_rx_valid();
      tx_alloc_i = tv ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 59) == 0);
      rx_alloc_i = rv ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 59) == 0);
      q.delete();
      for (int i = 0; i < NB; i++) if (m_alloc[i]) q.push_back(i);
      tx_release_i = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      rx_release_i = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      tx_res_tid_i = (q.size() > 0) ? W'(q[$urandom_range(0, q.size() - 1)]) : '0;
      rx_res_tid_i = (q.size() > 0) ? W'(q[$urandom_range(0, q.size() - 1)]) : '0;
      if ($urandom_range(0, 39) == 0) tx_res_tid_i = W'($urandom_range(0, NB - 1));
      if ($urandom_range(0, 39) == 0) rx_res_tid_i = W'($urandom_range(0, NB - 1));
      #1;
      low = m_lowest();
      exp_tid = (low < 0) ? 0 : low;
      exp_cnt = m_count();
      checks++; if (tid_o !== W'(exp_tid)) begin failures++; $display("FAIL rnd_tid cyc=%0d got=%0d exp=%0d", cyc, tid_o, exp_tid); end
      checks++; if ({tx_valid_tid_o, rx_valid_tid_o} !== {tv, rv}) begin failures++; $display("FAIL rnd_valids cyc=%0d got=%b exp=%b", cyc, {tx_valid_tid_o, rx_valid_tid_o}, {tv, rv}); end
      checks++; if (outstanding_o !== 5'(exp_cnt)) begin failures++; $display("FAIL rnd_outstanding cyc=%0d got=%0d exp=%0d", cyc, outstanding_o, exp_cnt); end
      checks++; if (idle_o !== (exp_cnt == 0)) begin failures++; $display("FAIL rnd_idle cyc=%0d got=%0b exp=%0b", cyc, idle_o, exp_cnt == 0); end
      checks++; if (err_o !== m_err) begin failures++; $display("FAIL rnd_err cyc=%0d got=%0b exp=%0b", cyc, err_o, m_err); end
      tick();
    end
    rst_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_tx();
    test_rr_alternate();
    test_fill_and_release();
    test_dual_release();
    test_alloc_release_same();
    test_errors();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
